// File: rtl/dpram_burst_pkg.sv
// Shared types and default sizing for the DPRAM burst master.
package dpram_burst_pkg;

  localparam int DEF_DATA_WIDTH    = 8;
  localparam int DEF_ADDR_WIDTH    = 6;
  localparam int DEF_MAX_BURST_LEN = 4;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    WR_BURST,
    RD_BURST,
    RD_TAIL
  } state_t;

  // Width of a "beats minus one" field; never narrower than one bit.
  function automatic int len_width(input int max_len);
    return (max_len > 1) ? $clog2(max_len) : 1;
  endfunction

endpackage

// File: rtl/burst_beat_buf.sv
// Small register file that stages host write words until the RAM burst runs.
module burst_beat_buf #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int IW         = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_word
);

  logic [DATA_WIDTH-1:0] slot [DEPTH];
  logic [IW-1:0]         wr_idx_reg;
  logic [IW-1:0]         rd_idx_reg;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [DATA_WIDTH-1:0] word_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          word_reg <= '0;
        end else if (wr_en && (wr_idx_reg == IW'(gi))) begin
          word_reg <= wr_data;
        end
      end

      assign slot[gi] = word_reg;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx_reg <= '0;
      rd_idx_reg <= '0;
    end else if (clr) begin
      wr_idx_reg <= '0;
      rd_idx_reg <= '0;
    end else begin
      if (wr_en) wr_idx_reg <= wr_idx_reg + 1'b1;
      if (rd_en) rd_idx_reg <= rd_idx_reg + 1'b1;
    end
  end

  // A single-beat burst reads slot 0 in the same cycle it is written.
  assign rd_word = (wr_en && (wr_idx_reg == rd_idx_reg)) ? wr_data : slot[rd_idx_reg];

endmodule

// File: rtl/dpram_burst_master.sv
// Host-side burst master driving one burst port of a dual-port RAM.
module dpram_burst_master
  import dpram_burst_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int MAX_BURST_LEN = DEF_MAX_BURST_LEN,
  localparam int LW           = len_width(MAX_BURST_LEN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LW-1:0]         req_len,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_last,
  output logic                  done,
  output logic                  we,
  output logic                  burst_en,
  output logic [LW-1:0]         burst_len,
  output logic [ADDR_WIDTH-1:0] base_addr,
  output logic [DATA_WIDTH-1:0] din,
  input  logic [DATA_WIDTH-1:0] dout
);

  state_t                state_reg, state_next;
  logic [LW-1:0]         beat_reg, beat_next;
  logic [LW-1:0]         len_reg, len_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic                  done_next;
  logic                  accept, wr_fire, beat_last, bursting_next;
  logic [DATA_WIDTH-1:0] buf_word;

  assign accept        = (state_reg == IDLE) && req_valid && req_ready;
  assign wr_fire       = (state_reg == COLLECT) && wr_valid && wr_ready;
  assign beat_last     = (beat_reg == len_reg);
  assign bursting_next = (state_next == WR_BURST) || (state_next == RD_BURST);

  burst_beat_buf #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (MAX_BURST_LEN),
    .IW        (LW)
  ) u_beat_buf (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_reg == IDLE),
    .wr_en  (wr_fire),
    .wr_data(wr_data),
    .rd_en  (state_next == WR_BURST),
    .rd_word(buf_word)
  );

  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    len_next   = len_reg;
    addr_next  = addr_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          len_next   = req_len;
          addr_next  = req_addr;
          beat_next  = '0;
          state_next = req_we ? COLLECT : RD_BURST;
        end
      end
      COLLECT: begin
        if (wr_fire) begin
          if (beat_last) begin
            beat_next  = '0;
            state_next = WR_BURST;
          end else begin
            beat_next = beat_reg + 1'b1;
          end
        end
      end
      WR_BURST: begin
        if (beat_last) begin
          beat_next  = '0;
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          beat_next = beat_reg + 1'b1;
        end
      end
      RD_BURST: begin
        if (beat_last) begin
          beat_next  = '0;
          state_next = RD_TAIL;
          done_next  = 1'b1;
        end else begin
          beat_next = beat_reg + 1'b1;
        end
      end
      RD_TAIL: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from next-state so they line up with state_reg.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      beat_reg  <= '0;
      len_reg   <= '0;
      addr_reg  <= '0;
      req_ready <= 1'b1;
      wr_ready  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      done      <= 1'b0;
      we        <= 1'b0;
      burst_en  <= 1'b0;
      burst_len <= '0;
      base_addr <= '0;
      din       <= '0;
    end else begin
      state_reg <= state_next;
      beat_reg  <= beat_next;
      len_reg   <= len_next;
      addr_reg  <= addr_next;
      // Held low during the done cycle so a new request lands strictly after it.
      req_ready <= (state_next == IDLE) && !done_next;
      wr_ready  <= (state_next == COLLECT);
      rd_valid  <= (state_reg == RD_BURST);
      rd_last   <= (state_next == RD_TAIL);
      done      <= done_next;
      we        <= (state_next == WR_BURST);
      burst_en  <= bursting_next;
      burst_len <= bursting_next ? len_next : '0;
      base_addr <= bursting_next ? addr_next : '0;
      din       <= (state_next == WR_BURST) ? buf_word : '0;
    end
  end

  assign rd_data = rd_valid ? dout : '0;

endmodule

// File: tb/tb_dpram_burst_master.sv
// Directed bench: burst master wired to a behavioural DPRAM burst port.
module tb_dpram_burst_master;

  localparam int DW = 8;
  localparam int AW = 6;
  localparam int LW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_len;
  logic [DW-1:0] wr_data;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid, rd_last, done, we, burst_en;
  logic [LW-1:0] burst_len;
  logic [AW-1:0] base_addr;
  logic [DW-1:0] din, dout;

  logic [DW-1:0] ram [64];
  logic [AW-1:0] ram_cnt = '0;
  logic [AW-1:0] ram_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dpram_burst_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .done(done),
    .we(we), .burst_en(burst_en), .burst_len(burst_len),
    .base_addr(base_addr), .din(din), .dout(dout)
  );

  // RAM burst port: address advances internally, modulo 64, while burst_en holds.
  assign ram_addr = base_addr + ram_cnt;

  always @(posedge clk) begin
    if (burst_en) begin
      if (we) ram[ram_addr] <= din;
      else    dout <= ram[ram_addr];
      ram_cnt <= ram_cnt + 1'b1;
    end else begin
      ram_cnt <= '0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("req_ready_timeout", req_ready, 1);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [LW-1:0] l,
                          input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                          input logic [DW-1:0] d2, input logic [DW-1:0] d3,
                          input bit gaps);
    logic [DW-1:0] d [4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    wait_ready();
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_len = l;
    @(negedge clk);
    req_valid = 1'b0;
    check("wr_ready_collect", wr_ready, 1);
    for (int i = 0; i <= int'(l); i++) begin
      wr_valid = 1'b1; wr_data = d[i];
      @(negedge clk);
      wr_valid = 1'b0;
      if (gaps && i < int'(l)) begin
        check("gap_no_burst", burst_en, 0);
        @(negedge clk);
      end
    end
    for (int i = 0; i <= int'(l); i++) begin
      check("wr_burst_en", burst_en, 1);
      check("wr_we", we, 1);
      check("wr_base", base_addr, a);
      check("wr_len", burst_len, l);
      check("wr_din", din, d[i]);
      check("wr_ready_off", wr_ready, 0);
      @(negedge clk);
    end
    check("wr_done", done, 1);
    check("wr_burst_end", burst_en, 0);
    check("wr_no_accept_on_done", req_ready, 0);
    @(negedge clk);
    check("wr_done_pulse", done, 0);
    check("wr_ready_after", req_ready, 1);
    $display("write burst addr %0d len %0d", a, l);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [LW-1:0] l,
                         input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                         input logic [DW-1:0] e2, input logic [DW-1:0] e3,
                         input int rst_beat);
    logic [DW-1:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    wait_ready();
    req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_len = l;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i <= int'(l); i++) begin
      check("rd_burst_en", burst_en, 1);
      check("rd_we", we, 0);
      check("rd_base", base_addr, a);
      check("rd_len", burst_len, l);
      check("rd_valid_beat", rd_valid, (i > 0) ? 1 : 0);
      if (i > 0) check("rd_data_beat", rd_data, e[i-1]);
      check("rd_last_early", rd_last, 0);
      if (i == rst_beat) begin
        rst = 1'b1;
        #1;
        check("rst_burst_en", burst_en, 0);
        check("rst_we", we, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_rd_last", rd_last, 0);
        check("rst_done", done, 0);
        check("rst_base", base_addr, 0);
        check("rst_len", burst_len, 0);
        check("rst_din", din, 0);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_req_ready", req_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("post_rst_rd_valid", rd_valid, 0);
          check("post_rst_burst_en", burst_en, 0);
          check("post_rst_req_ready", req_ready, 1);
        end
        $display("read burst addr %0d len %0d aborted by reset at beat %0d", a, l, i);
        return;
      end
      @(negedge clk);
    end
    check("rd_tail_burst_en", burst_en, 0);
    check("rd_tail_valid", rd_valid, 1);
    check("rd_tail_data", rd_data, e[l]);
    check("rd_last", rd_last, 1);
    check("rd_done", done, 1);
    @(negedge clk);
    check("rd_valid_end", rd_valid, 0);
    check("rd_done_pulse", done, 0);
    check("rd_ready_after", req_ready, 1);
    $display("read burst addr %0d len %0d", a, l);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0;
    wr_data = '0; wr_valid = 1'b0;
    for (int i = 0; i < 64; i++) ram[i] = '0;
    #1;
    check("reset_req_ready", req_ready, 1);
    check("reset_wr_ready", wr_ready, 0);
    check("reset_burst_en", burst_en, 0);
    check("reset_we", we, 0);
    check("reset_done", done, 0);
    check("reset_rd_valid", rd_valid, 0);
    check("reset_din", din, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Write words offered while idle must be ignored.
    wr_valid = 1'b1; wr_data = 8'h55;
    @(negedge clk);
    check("idle_wr_ready", wr_ready, 0);
    check("idle_burst_en", burst_en, 0);
    wr_valid = 1'b0;

    do_write(6'd0, 2'd3, 8'h11, 8'h22, 8'h33, 8'h44, 1'b0);
    check("ram0", ram[0], 8'h11);
    check("ram1", ram[1], 8'h22);
    check("ram2", ram[2], 8'h33);
    check("ram3", ram[3], 8'h44);
    do_read(6'd0, 2'd3, 8'h11, 8'h22, 8'h33, 8'h44, -1);

    do_write(6'd62, 2'd3, 8'hE1, 8'hE2, 8'hE3, 8'hE4, 1'b0);
    check("ram62", ram[62], 8'hE1);
    check("ram63", ram[63], 8'hE2);
    check("ram0_wrap", ram[0], 8'hE3);
    check("ram1_wrap", ram[1], 8'hE4);
    do_read(6'd62, 2'd3, 8'hE1, 8'hE2, 8'hE3, 8'hE4, -1);

    // Single-beat write with a read request held high throughout.
    wait_ready();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 6'd16; req_len = 2'd0;
    @(negedge clk);
    check("hold_collect", wr_ready, 1);
    req_we = 1'b0;
    wr_valid = 1'b1; wr_data = 8'hAA;
    @(negedge clk);
    wr_valid = 1'b0;
    check("hold_beat_en", burst_en, 1);
    check("hold_beat_we", we, 1);
    check("hold_beat_din", din, 8'hAA);
    check("hold_busy", req_ready, 0);
    @(negedge clk);
    check("hold_done", done, 1);
    check("hold_single_beat", burst_en, 0);
    check("hold_not_accepted", req_ready, 0);
    @(negedge clk);
    check("hold_ready_after_done", req_ready, 1);
    check("hold_still_idle", burst_en, 0);
    @(negedge clk);
    req_valid = 1'b0;
    check("hold_read_started", burst_en, 1);
    check("hold_read_we", we, 0);
    check("hold_read_base", base_addr, 16);
    @(negedge clk);
    check("hold_read_valid", rd_valid, 1);
    check("hold_read_data", rd_data, 8'hAA);
    check("hold_read_done", done, 1);
    check("ram16", ram[16], 8'hAA);
    $display("single-beat write addr 16 then held read request");
    @(negedge clk);

    do_write(6'd8, 2'd1, 8'h5A, 8'hA5, 8'h00, 8'h00, 1'b1);
    check("ram8", ram[8], 8'h5A);
    check("ram9", ram[9], 8'hA5);

    do_read(6'd62, 2'd3, 8'hE1, 8'hE2, 8'hE3, 8'hE4, 2);
    do_read(6'd8, 2'd1, 8'h5A, 8'hA5, 8'h00, 8'h00, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/dpram_burst_master.md
DPRAM_BURST_MASTER -- requirements
Module: dpram_burst_master

Interface
REQ-001 Parameter DATA_WIDTH, default 8, word width of data on both sides SHALL be supported.
REQ-002 Parameter ADDR_WIDTH, default 6, address width (64 locations) SHALL be supported.
REQ-003 Parameter MAX_BURST_LEN, default 4, maximum beats per burst; LW = $clog2(MAX_BURST_LEN) SHALL size all length fields.
REQ-004 Ports SHALL be, one clock, reset asynchronous active-high:
 clk  in  1  rising-edge clock
 rst  in  1  asynchronous active-high reset
 req_valid  in  1  host burst request
 req_ready  out  1  master idle, request accepted when both high
 req_we  in  1  1=write burst, 0=read burst
 req_addr  in  ADDR_WIDTH  burst base address
 req_len  in  LW  beats minus one
 wr_data  in  DATA_WIDTH  write word from host
 wr_valid  in  1  write word valid
 wr_ready  out  1  master accepts write word
 rd_data  out  DATA_WIDTH  read word to host
 rd_valid  out  1  read word valid (no backpressure)
 rd_last  out  1  final read word of burst
 done  out  1  one-cycle burst-complete pulse
 we  out  1  RAM port write enable
 burst_en  out  1  RAM port burst enable
 burst_len  out  LW  RAM port burst length (beats minus one)
 base_addr  out  ADDR_WIDTH  RAM port base address
 din  out  DATA_WIDTH  RAM port write data
 dout  in  DATA_WIDTH  RAM port read data, valid one cycle after each read beat

Function
REQ-005 FSM states SHALL be IDLE, COLLECT, WR_BURST, RD_BURST, RD_TAIL.
REQ-006 IDLE: req_ready=1; on req_valid latch req_we/addr/len; go COLLECT if req_we else RD_BURST.
REQ-007 COLLECT: wr_ready=1; each wr_valid&wr_ready stores wr_data into beat buffer slot 0..len; after len+1 words go WR_BURST.
REQ-008 WR_BURST: exactly len+1 consecutive cycles with burst_en=1, we=1, base_addr/burst_len = latched values, din = buffer[beat]; then IDLE with done=1 for one cycle.
REQ-009 RD_BURST: exactly len+1 consecutive cycles with burst_en=1, we=0, latched base_addr/burst_len; then RD_TAIL for one cycle, then IDLE.
REQ-010 rd_valid SHALL be high the cycle after each read beat with rd_data=dout; rd_last and done high together with the final word.
REQ-011 All RAM-side outputs and req_ready/wr_ready/rd_valid/rd_last/done SHALL be registered; burst_en SHALL never have gaps inside a burst.
REQ-012 base_addr SHALL be passed unmodified; address wrap beyond 2**ADDR_WIDTH-1 is modulo in the RAM, not in the master.
REQ-013 req_valid while not IDLE SHALL be ignored (req_ready=0); wr_valid outside COLLECT SHALL be ignored.
REQ-014 req_len=0 SHALL produce a single-beat burst; req_len=MAX_BURST_LEN-1 a full burst.
REQ-015 Back-to-back requests: a new request SHALL be accepted no earlier than the cycle after done.

Reset
REQ-016 rst SHALL force IDLE, req_ready=1, and all other outputs (wr_ready, rd_*, done, we, burst_en, burst_len, base_addr, din) to 0 immediately, including mid-burst.
REQ-017 Buffer contents and beat counters SHALL be discarded on reset; no partial burst resumes after release.

Structure
REQ-018 Package dpram_burst_pkg SHALL hold the FSM state type and default DATA_WIDTH/ADDR_WIDTH/MAX_BURST_LEN constants.
REQ-019 Beat buffer SHALL be a sub-module burst_beat_buf (MAX_BURST_LEN x DATA_WIDTH registers, write index, read index).

Verification (master connected to DPRAM burst port A)
REQ-020 Write addr 0, len 3, data 11,22,33,44 -> four WR_BURST beats, din 11..44, done one cycle after last beat; RAM[0..3]=11,22,33,44.
REQ-021 Read addr 0, len 3 -> rd_valid 4 cycles, rd_data 11,22,33,44, rd_last+done on 44.
REQ-022 Write addr 62, len 3, data E1..E4 -> RAM[62],[63],[0],[1] = E1..E4; read back matches.
REQ-023 Write len 0 addr 16 data AA, then req_valid held during burst -> single beat, second request accepted only after done.
REQ-024 Assert rst during 3rd read beat -> all outputs 0 that cycle, req_ready=1 after release, no further rd_valid.
REQ-025 wr_valid toggling 1,0,1,0 in COLLECT for len 1 -> burst starts only after second word; din order preserved.
